// File: rtl/ram8_demux_bank.sv
// 8-word register bank: one-hot load demux, 8-way read mux, and a
// sequential clear engine that zeroes one word per cycle while busy is high.
module ram8_demux_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_ptr;
  logic [2:0]       w_ptr_nxt;
  logic [WIDTH-1:0] r_mem [8];
  logic [7:0]       w_sel;
  logic [7:0]       w_ptr_sel;
  logic [7:0]       w_we;
  logic [WIDTH-1:0] w_wdata;

  assign w_sel     = 8'(8'b1 << address);
  assign w_ptr_sel = 8'(8'b1 << r_ptr);

  // A clear accepted in IDLE suppresses the load of that same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_we        = '0;
    w_wdata     = in;
    case (r_state)
      IDLE: begin
        if (clear) begin
          w_state_nxt = SWEEP;
          w_ptr_nxt   = 3'd0;
        end else if (load) begin
          w_we = w_sel;
        end
      end
      SWEEP: begin
        w_we      = w_ptr_sel;
        w_wdata   = '0;
        w_ptr_nxt = r_ptr + 3'd1;
        if (r_ptr == 3'd7) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      for (int i = 0; i < 8; i++) begin
        if (w_we[i]) begin
          r_mem[i] <= w_wdata;
        end
      end
    end
  end

  assign out  = r_mem[address];
  assign busy = (r_state == SWEEP);

endmodule

// File: tb/tb_ram8_demux_bank.sv
// Scoreboard bench for ram8_demux_bank: directed scenarios plus random traffic
// checked against an edge-level behavioural model of the bank.
module tb_ram8_demux_bank;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in;
  logic             load;
  logic [2:0]       address;
  logic             clear;
  logic [WIDTH-1:0] out;
  logic             busy;

  ram8_demux_bank #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (out),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             busy;
    int               phase;
    int               step;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  logic [WIDTH-1:0] m_mem [8];
  bit               m_sweeping;
  int               m_edge;
  int               m_start_edge;
  int               phase;
  int               step_no;

  // Inputs currently applied (consumed by the model at the next edge)
  logic             a_rst_n;
  logic             a_load;
  logic [2:0]       a_addr;
  logic [WIDTH-1:0] a_in;
  logic             a_clear;

  // Apply one rising edge to the model: word k of a sweep accepted at edge S
  // is zeroed at edge S+1+k.
  task automatic model_edge();
    int k;
    m_edge++;
    if (!a_rst_n) begin
      for (int i = 0; i < 8; i++) m_mem[i] = '0;
      m_sweeping = 1'b0;
    end else if (m_sweeping) begin
      k = m_edge - m_start_edge - 1;
      m_mem[k] = '0;
      if (k == 7) m_sweeping = 1'b0;
    end else if (a_clear) begin
      m_sweeping   = 1'b1;
      m_start_edge = m_edge;
    end else if (a_load) begin
      m_mem[a_addr] = a_in;
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [2:0] a,
                      input logic [WIDTH-1:0] d, input logic c);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    rst_n = r; load = l; address = a; in = d; clear = c;
    a_rst_n = r; a_load = l; a_addr = a; a_in = d; a_clear = c;
    step_no++;
    e.out   = m_mem[a];
    e.busy  = m_sweeping;
    e.phase = phase;
    e.step  = step_no;
    exp_q.push_back(e);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1'b1, 1'b0, a, 16'h0000, 1'b0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [WIDTH-1:0] d);
    step(1'b1, 1'b1, a, d, 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 8; i++) rd(3'(i));
  endtask

  task automatic fill_mult();
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h1111 * i));
  endtask

  // Monitor: compares every presented output against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (out !== e.out) begin
        bad++;
        $display("FAIL out phase=%0d step=%0d addr=%0d got=%h want=%h",
                 e.phase, e.step, address, out, e.out);
      end
      total++;
      if (busy !== e.busy) begin
        bad++;
        $display("FAIL busy phase=%0d step=%0d got=%b want=%b",
                 e.phase, e.step, busy, e.busy);
      end
    end
  end

  initial begin
    int wait_cyc;
    m_sweeping = 1'b0; m_edge = 0; m_start_edge = 0; step_no = 0;
    for (int i = 0; i < 8; i++) m_mem[i] = 'x;
    rst_n = 1'b0; load = 1'b0; address = 3'd0; in = '0; clear = 1'b0;
    a_rst_n = 1'b0; a_load = 1'b0; a_addr = 3'd0; a_in = '0; a_clear = 1'b0;

    phase = 1;
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0);
    read_all();

    phase = 2;
    wr(3'd0, 16'h1234);
    wr(3'd3, 16'hBEEF);
    wr(3'd7, 16'hFFFF);
    read_all();

    phase = 3;
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hA5A5);
    wr(3'd5, 16'h0001);
    read_all();

    phase = 4;
    fill_mult();
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1);
    for (int i = 0; i < 10; i++) rd(3'(i % 8));
    for (int i = 0; i < 10; i++) rd(3'((i + 3) % 8));
    read_all();

    phase = 5;
    fill_mult();
    step(1'b1, 1'b1, 3'd2, 16'h5555, 1'b1);
    rd(3'd2);
    rd(3'd2);
    step(1'b1, 1'b1, 3'd4, 16'h7777, 1'b0);
    step(1'b1, 1'b0, 3'd4, 16'h0, 1'b1);
    step(1'b1, 1'b0, 3'd4, 16'h0, 1'b1);
    for (int i = 0; i < 6; i++) rd(3'd4);
    read_all();

    phase = 6;
    fill_mult();
    step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1);
    rd(3'd5); rd(3'd5); rd(3'd5);
    step(1'b0, 1'b0, 3'd5, 16'h0, 1'b0);
    wr(3'd6, 16'h0F0F);
    read_all();

    phase = 7;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(49) != 0),
           $urandom_range(1) == 1,
           3'($urandom_range(7)),
           16'($urandom),
           ($urandom_range(11) == 0));
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain remaining=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram8_demux_bank.md
Name: ram8_demux_bank

Overview:
- 8-word register bank for the CPU memory hierarchy: the distribution side of the 8-way bus logic.
- One input word is routed to one of eight registers through an 8-way one-hot load demultiplexer.
- The eight registers are read back through an 8-way output multiplexer.
- A sequential clear engine sweeps all eight words to zero on request, with a busy indication.

Parameters:
- WIDTH, 16, data word width in bits (Hack word size).
- Depth is fixed at 8 words. The address is fixed at 3 bits. Neither is parameterised.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in  input  WIDTH  write data.
- load  input  1  write enable for the word selected by address.
- address  input  3  word select for write and read.
- clear  input  1  request to zero all eight words; level sampled each cycle.
- out  output  WIDTH  read data = word[address].
- busy  output  1  high while the clear sweep is in progress.

Behaviour:
Reset:
- rst_n=0 at a rising edge sets all 8 words to 0, state to IDLE, sweep pointer to 0 and busy to 0.
- out therefore reads 0 for every address after reset.
- Reset has priority over every other input, including mid-sweep: the sweep is aborted and the next state is IDLE.

Load demux:
- Decode address into an 8-bit one-hot select.
- Each word's enable = load & select[i] & ~busy & ~clear_accept.
- At most one word is written per edge.
- Non-selected words hold their value.

Read mux:
- out = word[address], purely combinational from the registers and address. Zero-cycle read latency.
- A write at edge N is visible on out after edge N; no write-through in the same cycle.

FSM states: IDLE, SWEEP.
- IDLE:
  - clear=1 -> clear_accept. Next state is SWEEP, pointer = 0.
  - Any load in the same cycle as clear_accept is dropped.
  - Otherwise a normal load/write is performed.
- SWEEP:
  - Each edge writes 0 to word[pointer] and increments the pointer.
  - When pointer=7 is written, next state is IDLE and the pointer wraps to 0.
  - load is ignored (no word written) while in SWEEP.
  - clear is ignored while in SWEEP (no restart, no extension).
- busy = (state == SWEEP). Registered-state decode, no combinational path from clear.

Timing:
- clear sampled at edge N.
- busy is high from after edge N until after edge N+8, i.e. exactly 8 cycles.
- Word k is zeroed at edge N+1+k.
- A held clear re-triggers a new sweep on the first IDLE edge after the sweep ends.

Width rules:
- in is stored verbatim: no extension, no truncation.
- address has no out-of-range values (3 bits covers 0..7).

Test Plan:
1. Reset: rst_n=0 for 2 edges, then sweep address 0..7 -> out=0x0000 for every address; busy=0.
2. Write/readback: load=1 with (address,in) = (0,0x1234), (3,0xBEEF), (7,0xFFFF) on successive edges, then read 0..7 -> 0x1234 at 0, 0xBEEF at 3, 0xFFFF at 7, 0x0000 elsewhere. Each value appears on out only after its write edge.
3. Demux isolation: write 0xA5A5 to all 8 words, then load 0x0001 at address 5 -> only word 5 = 0x0001; the other seven remain 0xA5A5.
4. Clear sweep:
   - Fill words with 0x1111*k, pulse clear for 1 cycle.
   - busy=1 for exactly 8 cycles.
   - Monitor: word k reads 0 from edge N+1+k onward, words not yet reached keep their value.
   - After the sweep, all 8 words read 0 and busy=0.
5. Conflicts:
   - clear=1 and load=1 (address 2, 0x5555) on the same edge -> word 2 not written.
   - load=0x7777 to address 4 mid-sweep -> ignored; word 4 ends at 0.
   - clear re-asserted mid-sweep -> busy still drops after 8 cycles.
6. Reset mid-sweep: rst_n=0 at sweep cycle 3 -> state IDLE, busy=0 next cycle, all words 0. A load to address 6 of 0x0F0F on the following edge succeeds.
